// File: rtl/axi_wdata_target_mux_if.sv
// ---------------------------------------------------------------------------
// axi_wdata_target_mux_if
//
// Purpose: bundles the burst-order push port, the merged W source ports and
// the single W target port of axi_wdata_target_mux.
//
// Signals (directions seen from the mux, i.e. the "slave" modport):
//   push_id_i    in   AW arbiter granted a burst
//   id_i         in   one-hot initiator of the granted burst
//   grant_fifo_o out  order FIFO can accept a push
//   wvalid_i     in   per-source W valid
//   wlast_i      in   per-source W last
//   wpayload_i   in   per-source payload, source k at [k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   wready_o     out  per-source W ready
//   wvalid_o     out  W valid toward the target
//   wlast_o      out  W last toward the target
//   wpayload_o   out  W payload toward the target
//   wready_i     in   target W ready
//   pending_o    out  bursts queued, head included
// ---------------------------------------------------------------------------
interface axi_wdata_target_mux_if #(
    parameter int N_TARG_PORT   = 4,
    parameter int PAYLOAD_WIDTH = 74,
    parameter int FIFO_DEPTH    = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                                   push_id_i;
    logic [N_TARG_PORT-1:0]                 id_i;
    logic                                   grant_fifo_o;
    logic [N_TARG_PORT-1:0]                 wvalid_i;
    logic [N_TARG_PORT-1:0]                 wlast_i;
    logic [N_TARG_PORT*PAYLOAD_WIDTH-1:0]   wpayload_i;
    logic [N_TARG_PORT-1:0]                 wready_o;
    logic                                   wvalid_o;
    logic                                   wlast_o;
    logic [PAYLOAD_WIDTH-1:0]               wpayload_o;
    logic                                   wready_i;
    logic [CNT_W-1:0]                       pending_o;

    modport slave (
        input  push_id_i, id_i, wvalid_i, wlast_i, wpayload_i, wready_i,
        output grant_fifo_o, wready_o, wvalid_o, wlast_o, wpayload_o, pending_o
    );

    modport master (
        output push_id_i, id_i, wvalid_i, wlast_i, wpayload_i, wready_i,
        input  grant_fifo_o, wready_o, wvalid_o, wlast_o, wpayload_o, pending_o
    );
endinterface

// File: rtl/axi_wdata_target_mux.sv
// ---------------------------------------------------------------------------
// axi_wdata_target_mux
//
// Purpose: merges the W streams of N_TARG_PORT sources onto one target W
// channel. Granted bursts are recorded (one-hot initiator) in an order FIFO;
// beats are forwarded strictly in that order and the FIFO head is popped
// when the selected beat carrying last is accepted.
//
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   test_en_i  in  test mode, no functional effect
//   bus        axi_wdata_target_mux_if.slave (push port, W sources, W target)
//
// Build option: AXI_WDATA_TARGET_MUX_OUT_REG_EN
//   defined   -> a 2-entry skid buffer registers the target-side W outputs;
//                source ready then depends only on buffer occupancy.
//   undefined -> valid/last/payload/ready are combinational pass-through.
// ---------------------------------------------------------------------------
module axi_wdata_target_mux #(
    parameter int N_TARG_PORT   = 4,
    parameter int PAYLOAD_WIDTH = 74,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          test_en_i,
    axi_wdata_target_mux_if.slave         bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Test mode has no function here; tied off to a sink.
    logic w_unused_test_en;
    assign w_unused_test_en = test_en_i;

    // ---------------- order FIFO ----------------
    logic [N_TARG_PORT-1:0] r_order_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_full;
    logic                   w_head_valid;
    logic [N_TARG_PORT-1:0] w_id_low;
    logic                   w_push;
    logic                   w_pop;
    logic [N_TARG_PORT-1:0] w_sel;

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head_valid = (r_count != '0);

    // Two's-complement trick isolates the lowest set bit; an all-zero id
    // yields zero and the push is dropped below.
    assign w_id_low = bus.id_i & (~bus.id_i + 1'b1);
    assign w_push   = bus.push_id_i & ~w_full & (|bus.id_i);

    // Empty FIFO selects nothing, so every source is held back.
    assign w_sel = w_head_valid ? r_order_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_order_mem[r_wr_ptr] <= w_id_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.grant_fifo_o = ~w_full;
    assign bus.pending_o    = r_count;

    // ---------------- source mux (one-hot AND-OR) ----------------
    logic [PAYLOAD_WIDTH-1:0] w_pay_terms [N_TARG_PORT];
    logic [PAYLOAD_WIDTH-1:0] w_mux_payload;
    logic                     w_mux_valid;
    logic                     w_mux_last;
    logic                     w_mux_ready;
    logic                     w_mux_fire;

    for (genvar gi = 0; gi < N_TARG_PORT; gi++) begin : g_pay_mask
        assign w_pay_terms[gi] = bus.wpayload_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
                               & {PAYLOAD_WIDTH{w_sel[gi]}};
    end

    always_comb begin
        w_mux_payload = '0;
        for (int k = 0; k < N_TARG_PORT; k++) begin
            w_mux_payload = w_mux_payload | w_pay_terms[k];
        end
    end

    assign w_mux_valid = |(w_sel & bus.wvalid_i);
    assign w_mux_last  = |(w_sel & bus.wlast_i);
    assign w_mux_fire  = w_mux_valid & w_mux_ready;
    assign w_pop       = w_mux_fire & w_mux_last;

    assign bus.wready_o = w_sel & {N_TARG_PORT{w_mux_ready}};

`ifdef AXI_WDATA_TARGET_MUX_OUT_REG_EN
    // ---------------- 2-entry skid buffer ----------------
    // r_skid_head always drives the target port; r_skid_tail only fills when
    // the target stalls while a beat is already held.
    logic [PAYLOAD_WIDTH:0] r_skid_head;
    logic [PAYLOAD_WIDTH:0] r_skid_tail;
    logic [1:0]             r_skid_cnt;
    logic                   w_skid_pop;
    logic [PAYLOAD_WIDTH:0] w_mux_beat;

    assign w_mux_beat  = {w_mux_last, w_mux_payload};
    assign w_mux_ready = (r_skid_cnt != 2'd2);
    assign w_skid_pop  = (r_skid_cnt != 2'd0) & bus.wready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_head <= '0;
            r_skid_tail <= '0;
            r_skid_cnt  <= 2'd0;
        end else begin
            if (w_skid_pop) begin
                r_skid_head <= r_skid_tail;
            end
            // A beat lands in the head slot whenever the head is (or is about
            // to become) free; this write overrides the shift above.
            if (w_mux_fire) begin
                if ((r_skid_cnt == 2'd0) || ((r_skid_cnt == 2'd1) && w_skid_pop)) begin
                    r_skid_head <= w_mux_beat;
                end else begin
                    r_skid_tail <= w_mux_beat;
                end
            end
            case ({w_mux_fire, w_skid_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
                2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

    assign bus.wvalid_o   = (r_skid_cnt != 2'd0);
    assign bus.wlast_o    = r_skid_head[PAYLOAD_WIDTH];
    assign bus.wpayload_o = r_skid_head[PAYLOAD_WIDTH-1:0];
`else
    assign w_mux_ready    = bus.wready_i;
    assign bus.wvalid_o   = w_mux_valid;
    assign bus.wlast_o    = w_mux_last;
    assign bus.wpayload_o = w_mux_payload;
`endif

endmodule

// File: tb/tb_axi_wdata_target_mux.sv
// ---------------------------------------------------------------------------
// tb_axi_wdata_target_mux
//
// Directed bench for axi_wdata_target_mux. A queue-based model (burst order
// queue plus, with AXI_WDATA_TARGET_MUX_OUT_REG_EN, a 2-beat output queue)
// predicts the outputs; a negedge process compares every cycle. Literal
// expectations (beat order, cycle of each beat, occupancy) pin the model.
// ---------------------------------------------------------------------------
module tb_axi_wdata_target_mux;
    localparam int N  = 4;
    localparam int PW = 74;
    localparam int D  = 8;
`ifdef AXI_WDATA_TARGET_MUX_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic          last;
        logic [PW-1:0] pay;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic test_en = 1'b0;

    axi_wdata_target_mux_if #(.N_TARG_PORT(N), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(D)) bus ();

    axi_wdata_target_mux #(.N_TARG_PORT(N), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .test_en_i (test_en),
        .bus       (bus.slave)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Source-side stimulus queues and environment handshake record.
    beat_t          srcq [N][$];
    logic [N-1:0]   acc_s = '0;
    int             log_cyc [$];
    logic [PW-1:0]  log_pay [$];
    logic [N-1:0]   log_ready [$];
    logic [PW-1:0]  exp_q [$];

    // Model state.
    int             oq [$];
    beat_t          skq [$];
    logic           m_mux_valid, m_mux_last, m_mux_ready;
    logic [PW-1:0]  m_mux_pay;
    logic           m_valid, m_last, m_grant;
    logic [PW-1:0]  m_pay;
    logic [N-1:0]   m_ready;
    int             m_pending;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cycle, got, exp);
        end
    endtask

    function automatic int low_idx(input logic [N-1:0] id);
        for (int k = 0; k < N; k++) begin
            if (id[k]) return k;
        end
        return -1;
    endfunction

    function automatic beat_t mk(input logic last, input logic [PW-1:0] pay);
        beat_t b;
        b.last = last;
        b.pay  = pay;
        return b;
    endfunction

    // Outputs implied by the order queue and the current source inputs.
    function automatic void model_eval();
        int s;
        s = (oq.size() > 0) ? oq[0] : -1;
        m_mux_valid = 1'b0;
        m_mux_last  = 1'b0;
        m_mux_pay   = '0;
        if (s >= 0) begin
            m_mux_valid = bus.wvalid_i[s];
            m_mux_last  = bus.wlast_i[s];
            m_mux_pay   = bus.wpayload_i[s*PW +: PW];
        end
`ifdef AXI_WDATA_TARGET_MUX_OUT_REG_EN
        m_mux_ready = (skq.size() < 2);
        m_valid     = (skq.size() > 0);
        m_last      = m_valid ? skq[0].last : 1'b0;
        m_pay       = m_valid ? skq[0].pay  : '0;
`else
        m_mux_ready = bus.wready_i;
        m_valid     = m_mux_valid;
        m_last      = m_mux_last;
        m_pay       = m_mux_pay;
`endif
        m_ready   = (s >= 0 && m_mux_ready) ? N'(1 << s) : '0;
        m_grant   = (oq.size() < D);
        m_pending = oq.size();
    endfunction

    // Model state update on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            oq.delete();
            skq.delete();
        end else begin
            model_eval();
            if (bus.push_id_i && oq.size() < D && bus.id_i != '0)
                oq.push_back(low_idx(bus.id_i));
`ifdef AXI_WDATA_TARGET_MUX_OUT_REG_EN
            if (skq.size() > 0 && bus.wready_i)
                void'(skq.pop_front());
            if (m_mux_valid && m_mux_ready)
                skq.push_back(mk(m_mux_last, m_mux_pay));
`endif
            if (m_mux_valid && m_mux_ready && m_mux_last)
                void'(oq.pop_front());
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant",   bus.grant_fifo_o, 1);
            chk("rst_pending", bus.pending_o,    0);
            chk("rst_wvalid",  bus.wvalid_o,     0);
            chk("rst_wlast",   bus.wlast_o,      0);
            chk("rst_payload", bus.wpayload_o,   0);
            chk("rst_wready",  bus.wready_o,     0);
            acc_s <= '0;
        end else begin
            model_eval();
            chk("grant",   bus.grant_fifo_o, m_grant);
            chk("pending", bus.pending_o,    m_pending);
            chk("wready",  bus.wready_o,     m_ready);
            chk("wvalid",  bus.wvalid_o,     m_valid);
            if (m_valid) begin
                chk("wlast",   bus.wlast_o,    m_last);
                chk("payload", bus.wpayload_o, m_pay);
            end
            acc_s <= bus.wvalid_i & bus.wready_o;
            log_ready.push_back(bus.wready_o);
            if (bus.wvalid_o && bus.wready_i) begin
                log_cyc.push_back(cycle);
                log_pay.push_back(bus.wpayload_o);
            end
        end
    end

    task automatic drv();
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0) begin
                bus.wvalid_i[k]              = 1'b1;
                bus.wlast_i[k]               = srcq[k][0].last;
                bus.wpayload_i[k*PW +: PW]   = srcq[k][0].pay;
            end else begin
                bus.wvalid_i[k]              = 1'b0;
                bus.wlast_i[k]               = 1'b0;
                bus.wpayload_i[k*PW +: PW]   = '0;
            end
        end
    endtask

    // Advance one cycle; retire source beats the DUT accepted.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_s[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        end
        drv();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic push(input logic [N-1:0] id);
        bus.push_id_i = 1'b1;
        bus.id_i      = id;
        cyc();
        bus.push_id_i = 1'b0;
        bus.id_i      = '0;
    endtask

    task automatic log_clear();
        log_cyc.delete();
        log_pay.delete();
        log_ready.delete();
    endtask

    // Beats must appear in exp_q order on consecutive cycles from base+LAT.
    task automatic check_log(input string nm, input int base);
        chk({nm, "_count"}, log_pay.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_pay.size(); i++) begin
            chk({nm, "_pay"}, log_pay[i], exp_q[i]);
            chk({nm, "_cyc"}, log_cyc[i], base + LAT + i);
        end
        $display("[TB] %s: %0d beats checked", nm, exp_q.size());
    endtask

    function automatic logic [N-1:0] ready_union();
        logic [N-1:0] u;
        u = '0;
        foreach (log_ready[i]) u = u | log_ready[i];
        return u;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.push_id_i = 1'b0;
        bus.id_i      = '0;
        bus.wready_i  = 1'b0;
        bus.wvalid_i  = '0;
        bus.wlast_i   = '0;
        bus.wpayload_i = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drv();
        cyc();

        // 1: single 3-beat burst from source 1
        log_clear();
        bus.wready_i = 1'b1;
        srcq[1].push_back(mk(1'b0, 74'hA));
        srcq[1].push_back(mk(1'b0, 74'hB));
        srcq[1].push_back(mk(1'b1, 74'hC));
        drv();
        t0 = cycle;
        push(4'b0010);
        run(2);
        @(negedge clk);
        chk("t1_pending_c3", bus.pending_o, 1);
        cyc();
        @(negedge clk);
        chk("t1_pending_c4", bus.pending_o, 0);
        run(3);
        exp_q = {74'hA, 74'hB, 74'hC};
        check_log("t1", t0 + 1);
        chk("t1_ready_union", ready_union(), 4'b0010);

        // 2: back-to-back bursts 0,3,0 with every source valid
        log_clear();
        srcq[0].push_back(mk(1'b0, 74'h10));
        srcq[0].push_back(mk(1'b1, 74'h11));
        srcq[0].push_back(mk(1'b0, 74'h12));
        srcq[0].push_back(mk(1'b1, 74'h13));
        srcq[3].push_back(mk(1'b0, 74'h30));
        srcq[3].push_back(mk(1'b1, 74'h31));
        srcq[1].push_back(mk(1'b0, 74'h99));
        srcq[2].push_back(mk(1'b0, 74'h98));
        drv();
        t0 = cycle;
        push(4'b0001);
        push(4'b1000);
        push(4'b0001);
        run(6);
        exp_q = {74'h10, 74'h11, 74'h30, 74'h31, 74'h12, 74'h13};
        check_log("t2", t0 + 1);
        srcq[1].delete();
        srcq[2].delete();
        drv();
        cyc();

        // 3: fill the order FIFO, refuse a ninth push, drain
        log_clear();
        for (int i = 0; i < 8; i++) push(4'(1 << (i % 4)));
        @(negedge clk);
        chk("t3_full_grant", bus.grant_fifo_o, 0);
        chk("t3_full_pending", bus.pending_o, 8);
        cyc();
        push(4'b0001);
        @(negedge clk);
        chk("t3_ninth_pending", bus.pending_o, 8);
        cyc();
        srcq[0].push_back(mk(1'b1, 74'h40));
        drv();
        t0 = cycle;
        cyc();
        @(negedge clk);
        chk("t3_regrant", bus.grant_fifo_o, 1);
        chk("t3_pending7", bus.pending_o, 7);
        run(LAT + 1);
        exp_q = {74'h40};
        check_log("t3a", t0);
        log_clear();
        srcq[0].push_back(mk(1'b1, 74'h41));
        srcq[1].push_back(mk(1'b1, 74'h42));
        srcq[1].push_back(mk(1'b1, 74'h43));
        srcq[2].push_back(mk(1'b1, 74'h44));
        srcq[2].push_back(mk(1'b1, 74'h45));
        srcq[3].push_back(mk(1'b1, 74'h46));
        srcq[3].push_back(mk(1'b1, 74'h47));
        drv();
        t0 = cycle;
        run(10);
        exp_q = {74'h42, 74'h44, 74'h46, 74'h41, 74'h43, 74'h45, 74'h47};
        check_log("t3b", t0);
        @(negedge clk);
        chk("t3_drained", bus.pending_o, 0);
        cyc();

        // 4: beat held back while the FIFO is empty
        log_clear();
        srcq[2].push_back(mk(1'b1, 74'h2A));
        drv();
        run(2);
        @(negedge clk);
        chk("t4_hold_wready", bus.wready_o, 0);
        chk("t4_hold_wvalid", bus.wvalid_o, 0);
        cyc();
        t0 = cycle;
        push(4'b0100);
        run(3);
        exp_q = {74'h2A};
        check_log("t4", t0 + 1);

        // 5: id sanitising
        log_clear();
        push(4'b0000);
        @(negedge clk);
        chk("t5_zero_pending", bus.pending_o, 0);
        cyc();
        log_clear();
        srcq[1].push_back(mk(1'b1, 74'h51));
        srcq[2].push_back(mk(1'b1, 74'h52));
        drv();
        t0 = cycle;
        push(4'b0110);
        run(4);
        @(negedge clk);
        chk("t5_multi_pending", bus.pending_o, 0);
        chk("t5_ready_union", ready_union(), 4'b0010);
        cyc();
        exp_q = {74'h51};
        check_log("t5", t0 + 1);
        srcq[2].delete();
        drv();
        cyc();

        // 6: reset in the middle of a burst with three bursts queued
        log_clear();
        for (int i = 0; i < 4; i++) srcq[0].push_back(mk(1'b0, 74'(96 + i)));
        drv();
        push(4'b0001);
        push(4'b0010);
        push(4'b0100);
        @(negedge clk);
        chk("t6_pre_pending", bus.pending_o, 3);
        chk("t6_pre_wvalid", bus.wvalid_o, 1);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant",   bus.grant_fifo_o, 1);
        chk("t6_async_pending", bus.pending_o,    0);
        chk("t6_async_wvalid",  bus.wvalid_o,     0);
        chk("t6_async_wlast",   bus.wlast_o,      0);
        chk("t6_async_payload", bus.wpayload_o,   0);
        chk("t6_async_wready",  bus.wready_o,     0);
        for (int k = 0; k < N; k++) srcq[k].delete();
        cyc();
        cyc();
        rst = 1'b0;
        drv();
        @(negedge clk);
        chk("t6_post_pending", bus.pending_o, 0);
        chk("t6_post_grant", bus.grant_fifo_o, 1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
